// File: rtl/ofm_writer_pkg.sv
// Shared definitions for the OFM writer: FSM encoding, tiling derivations,
// and the per-lane post-processing helpers.
package ofm_writer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int load_filters(input int no_filter, input int sys_size);
    return ceil_div(no_filter, sys_size);
  endfunction

  // The array always shifts out whole tiles, so each group carries padding rows.
  function automatic int rows_per_group(input int no_pixel, input int sys_size);
    return ceil_div(no_pixel, sys_size) * sys_size;
  endfunction

  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] x,
                                                  input int data_w,
                                                  input bit relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] y;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    y  = (relu && (x < 64'sd0)) ? 64'sd0 : x;
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    return y;
  endfunction

  function automatic logic lane_on(input int group, input int lane,
                                   input int no_filter, input int sys_size);
    return (group * sys_size + lane) < no_filter;
  endfunction

endpackage

// File: rtl/ofm_writer_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ofm_writer.sv
// Drains systolic-array result rows into OFM memory: ReLU/saturate each lane,
// tag with address and lane mask, buffer, and issue on a valid/ready port.
module ofm_writer
  import ofm_writer_pkg::*;
#(
  parameter int NO_FILTER     = 16,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int PSUM_W        = 32,
  parameter int DATA_W        = 16,
  parameter int NO_PIXEL      = 173056,
  parameter int FIFO_DEPTH    = 32,
  parameter int RELU          = 1,
  parameter int ADDR_W        = 22
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              write_out_en,
  input  logic [SYSTOLIC_SIZE*PSUM_W-1:0]   psum_in,
  output logic                              mem_wr_valid,
  input  logic                              mem_wr_ready,
  output logic [ADDR_W-1:0]                 mem_wr_addr,
  output logic [SYSTOLIC_SIZE*DATA_W-1:0]   mem_wr_data,
  output logic [SYSTOLIC_SIZE-1:0]          mem_wr_mask,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  localparam int NO_LOAD_FILTER = load_filters(NO_FILTER, SYSTOLIC_SIZE);
  localparam int NO_ROW_GROUP   = rows_per_group(NO_PIXEL, SYSTOLIC_SIZE);
  localparam int ROW_W          = $clog2(NO_ROW_GROUP + 1);
  localparam int GRP_W          = $clog2(NO_LOAD_FILTER + 1);
  localparam int ROW_DW         = SYSTOLIC_SIZE * DATA_W;
  localparam int ENT_W          = ADDR_W + SYSTOLIC_SIZE + ROW_DW;
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]         state;
  logic [ROW_W-1:0]   row_cnt;
  logic [GRP_W-1:0]   group_cnt;
  logic [ADDR_W-1:0]  group_base;

  logic               row_fire;
  logic               row_keep;
  logic               last_row;
  logic               last_group;

  logic [ROW_DW-1:0]          proc_data;
  logic [SYSTOLIC_SIZE-1:0]   proc_mask;

  logic                       vld_p0;
  logic [ADDR_W-1:0]          addr_p0;
  logic [ROW_DW-1:0]          data_p0;
  logic [SYSTOLIC_SIZE-1:0]   mask_p0;

  logic [ENT_W-1:0]           head;
  logic [ADDR_W-1:0]          head_addr;
  logic [SYSTOLIC_SIZE-1:0]   head_mask;
  logic [ROW_DW-1:0]          head_data;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic                       pop;
  logic                       drop;

  assign row_fire   = (state == ST_RUN) && write_out_en;
  assign row_keep   = row_cnt < ROW_W'(NO_PIXEL);
  assign last_row   = row_cnt == ROW_W'(NO_ROW_GROUP - 1);
  assign last_group = group_cnt == GRP_W'(NO_LOAD_FILTER - 1);

  always_comb begin
    proc_data = '0;
    proc_mask = '0;
    for (int j = 0; j < SYSTOLIC_SIZE; j++) begin
      proc_data[j*DATA_W +: DATA_W] =
        DATA_W'(relu_sat(64'(signed'(psum_in[j*PSUM_W +: PSUM_W])), DATA_W, RELU != 0));
      proc_mask[j] = lane_on(int'(group_cnt), j, NO_FILTER, SYSTOLIC_SIZE);
    end
  end

  // Stage p0: post-processed row; padding rows never set vld_p0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= row_fire && row_keep;
  end

  always_ff @(posedge clk) begin
    if (row_fire) begin
      addr_p0 <= group_base + ADDR_W'(row_cnt);
      data_p0 <= proc_data;
      mask_p0 <= proc_mask;
    end
  end

  // Stage p1: FIFO push; the head drives the memory port.
  assign pop  = !fifo_empty && mem_wr_ready;
  assign drop = vld_p0 && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_p0),
    .wr_data ({addr_p0, mask_p0, data_p0}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign {head_addr, head_mask, head_data} = head;

  // Storage is not reset, so the port is forced to zero whenever nothing is valid.
  assign mem_wr_valid = !fifo_empty;
  assign mem_wr_addr  = mem_wr_valid ? head_addr : '0;
  assign mem_wr_mask  = mem_wr_valid ? head_mask : '0;
  assign mem_wr_data  = mem_wr_valid ? head_data : '0;

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row_cnt    <= '0;
      group_cnt  <= '0;
      group_base <= '0;
      overflow   <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            row_cnt    <= '0;
            group_cnt  <= '0;
            group_base <= '0;
            overflow   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (write_out_en) begin
            if (last_row) begin
              row_cnt    <= '0;
              group_cnt  <= group_cnt + 1'b1;
              group_base <= group_base + ADDR_W'(NO_PIXEL);
              if (last_group) state <= ST_DRAIN;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!vld_p0 && (fifo_count == '0)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writer.sv
// Directed bench for ofm_writer: SYSTOLIC_SIZE=4, NO_FILTER=6, NO_PIXEL=10, FIFO_DEPTH=8,
// with a second instance built without ReLU.
module tb_ofm_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        wen;
  logic [127:0] psum;
  logic        ready;

  logic        valid, busy, done, ovf;
  logic [7:0]  addr;
  logic [63:0] data;
  logic [3:0]  mask;

  logic        nr_valid, nr_busy, nr_done, nr_ovf;
  logic [7:0]  nr_addr;
  logic [63:0] nr_data;
  logic [3:0]  nr_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [7:0]  wq_addr[$];
  logic [63:0] wq_data[$];
  logic [3:0]  wq_mask[$];

  always #5 clk = ~clk;

  ofm_writer #(.NO_FILTER(6), .SYSTOLIC_SIZE(4), .PSUM_W(32), .DATA_W(16), .NO_PIXEL(10),
               .FIFO_DEPTH(8), .RELU(1), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write_out_en(wen), .psum_in(psum),
    .mem_wr_valid(valid), .mem_wr_ready(ready), .mem_wr_addr(addr), .mem_wr_data(data),
    .mem_wr_mask(mask), .busy(busy), .done(done), .overflow(ovf));

  ofm_writer #(.NO_FILTER(6), .SYSTOLIC_SIZE(4), .PSUM_W(32), .DATA_W(16), .NO_PIXEL(10),
               .FIFO_DEPTH(8), .RELU(0), .ADDR_W(8)) dut_nr (
    .clk(clk), .rst_n(rst_n), .start(start), .write_out_en(wen), .psum_in(psum),
    .mem_wr_valid(nr_valid), .mem_wr_ready(ready), .mem_wr_addr(nr_addr), .mem_wr_data(nr_data),
    .mem_wr_mask(nr_mask), .busy(nr_busy), .done(nr_done), .overflow(nr_ovf));

  // Records each handshake that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (valid && ready) begin
      wq_addr.push_back(addr);
      wq_data.push_back(data);
      wq_mask.push_back(mask);
    end
    if (done) done_cnt++;
  end

  function automatic logic [127:0] psum_row(input int r);
    logic [127:0] p;
    for (int j = 0; j < 4; j++) p[j*32 +: 32] = 32'(r*16 + j);
    return p;
  endfunction

  function automatic logic [63:0] row_val(input int r);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(r*16 + j);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int base;
  int d0;
  logic       snap_v, snap_r;
  logic [7:0] snap_a;
  logic [63:0] snap_d;

  initial begin
    rst_n = 1'b0; start = 1'b0; wen = 1'b0; psum = '0; ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_mask", 64'(mask), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_nr_flags", 64'({nr_mask, nr_busy, nr_done, nr_ovf}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Rows offered while idle are ignored.
    base = wq_addr.size();
    wen = 1'b1; psum = psum_row(7);
    repeat (3) tick();
    wen = 1'b0;
    repeat (3) tick();
    chk("idle_writes", 64'(wq_addr.size() - base), 64'd0);
    chk("idle_valid", 64'(valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Full layer: 2 groups x 12 rows, plus 4 extra rows landing in DRAIN/DONE/IDLE.
    ready = 1'b1;
    base = wq_addr.size();
    d0 = done_cnt;
    do_start();
    chk("run_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 28; i++) begin
      wen = 1'b1; psum = psum_row(i);
      tick();
    end
    wen = 1'b0;
    repeat (40) tick();
    chk("layer_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("layer_writes", 64'(wq_addr.size() - base), 64'd20);
    for (int k = 0; k < 20 && base + k < wq_addr.size(); k++) begin
      chk($sformatf("layer_addr%0d", k), 64'(wq_addr[base+k]), 64'(k));
      chk($sformatf("layer_data%0d", k), wq_data[base+k], row_val(k < 10 ? k : k + 2));
      chk($sformatf("layer_mask%0d", k), 64'(wq_mask[base+k]), (k < 10) ? 64'hF : 64'h3);
    end
    chk("layer_ovf", 64'(ovf), 64'd0);
    chk("layer_busy_end", 64'(busy), 64'd0);

    // ReLU / saturation on both instances, and the 2-cycle latency.
    do_reset();
    ready = 1'b0;
    do_start();
    wen = 1'b1;
    psum = {32'sd123, -32'sd70000, 32'sd70000, -32'sd5};
    tick();
    wen = 1'b0;
    chk("lat_valid_early", 64'(valid), 64'd0);
    tick();
    chk("lat_valid", 64'(valid), 64'd1);
    chk("lat_addr", 64'(addr), 64'd0);
    chk("relu_data", data, 64'h007B_0000_7FFF_0000);
    chk("norelu_valid", 64'(nr_valid), 64'd1);
    chk("norelu_addr", 64'(nr_addr), 64'd0);
    chk("norelu_data", nr_data, 64'h007B_8000_7FFF_FFFB);

    // Stalled port: 8 rows fit, pixels 8 and 9 are dropped, 10/11 are padding.
    do_reset();
    ready = 1'b0;
    base = wq_addr.size();
    do_start();
    for (int i = 0; i < 12; i++) begin
      wen = 1'b1; psum = psum_row(i);
      tick();
    end
    wen = 1'b0;
    tick(); tick();
    chk("stall_ovf", 64'(ovf), 64'd1);
    chk("stall_valid", 64'(valid), 64'd1);
    chk("stall_addr", 64'(addr), 64'd0);
    chk("stall_writes", 64'(wq_addr.size() - base), 64'd0);
    ready = 1'b1;
    repeat (15) tick();
    chk("stall_drain_writes", 64'(wq_addr.size() - base), 64'd8);
    for (int k = 0; k < 8 && base + k < wq_addr.size(); k++) begin
      chk($sformatf("stall_addr%0d", k), 64'(wq_addr[base+k]), 64'(k));
      chk($sformatf("stall_data%0d", k), wq_data[base+k], row_val(k));
    end
    chk("stall_ovf_sticky", 64'(ovf), 64'd1);

    // Ready toggling every cycle: outputs must hold while stalled.
    do_reset();
    base = wq_addr.size();
    do_start();
    snap_v = 1'b0; snap_r = 1'b1; snap_a = '0; snap_d = '0;
    for (int i = 0; i < 30; i++) begin
      if (snap_v && !snap_r) begin
        chk($sformatf("hold_valid%0d", i), 64'(valid), 64'd1);
        chk($sformatf("hold_addr%0d", i), 64'(addr), 64'(snap_a));
        chk($sformatf("hold_data%0d", i), data, snap_d);
      end
      wen = (i < 10);
      psum = psum_row(i);
      ready = i[0];
      snap_v = valid; snap_r = ready; snap_a = addr; snap_d = data;
      tick();
    end
    wen = 1'b0;
    ready = 1'b1;
    repeat (5) tick();
    chk("toggle_writes", 64'(wq_addr.size() - base), 64'd10);
    for (int k = 0; k < 10 && base + k < wq_addr.size(); k++) begin
      chk($sformatf("toggle_addr%0d", k), 64'(wq_addr[base+k]), 64'(k));
      chk($sformatf("toggle_data%0d", k), wq_data[base+k], row_val(k));
    end
    chk("toggle_ovf", 64'(ovf), 64'd0);

    // Asynchronous reset mid-run, then a clean restart at address 0.
    do_reset();
    ready = 1'b0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; psum = psum_row(i + 20);
      tick();
    end
    wen = 1'b0;
    tick();
    chk("mid_valid_before", 64'(valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_addr", 64'(addr), 64'd0);
    chk("mid_rst_data", data, 64'd0);
    chk("mid_rst_mask", 64'(mask), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();
    do_start();
    wen = 1'b1; psum = psum_row(3);
    tick();
    wen = 1'b0;
    tick();
    chk("restart_valid", 64'(valid), 64'd1);
    chk("restart_addr", 64'(addr), 64'd0);
    chk("restart_data", data, row_val(3));
    chk("restart_mask", 64'(mask), 64'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_writer.md
# ofm_writer

Drain-side counterpart to the systolic-array main controller: consumes the result rows the array shifts out while `write_out_en` is high and writes them to output-feature-map (OFM) memory. Each accepted row is post-processed (optional ReLU, signed saturation PSUM_W→DATA_W), tagged with pixel/filter-group address and lane mask, buffered in a FIFO, and issued on a valid/ready memory write port. It tracks tiling and filter-group progress independently and flags completion once all groups are drained.

## Interface
- NO_FILTER, 16, total filters in the layer
- SYSTOLIC_SIZE, 16, array width (lanes per row = filters per group)
- PSUM_W, 32, signed partial-sum width per lane
- DATA_W, 16, signed OFM element width
- NO_PIXEL, 173056, output pixels per filter
- FIFO_DEPTH, 32, buffered rows (power of two)
- RELU, 1, 1 = clamp negatives to 0 before saturation
- ADDR_W, 22, OFM word address width (≥ clog2(NO_PIXEL·NO_LOAD_FILTER))
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, same pulse that launches the main controller
- write_out_en  in  1  result row valid from array this cycle
- psum_in  in  SYSTOLIC_SIZE·PSUM_W  row data, lane j at bits [j·PSUM_W +: PSUM_W]
- mem_wr_valid  out  1  write request
- mem_wr_ready  in  1  memory accepts when valid&ready
- mem_wr_addr  out  ADDR_W  group·NO_PIXEL + pixel
- mem_wr_data  out  SYSTOLIC_SIZE·DATA_W  processed row
- mem_wr_mask  out  SYSTOLIC_SIZE  lane j set iff group·SYSTOLIC_SIZE + j < NO_FILTER
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse on completion
- overflow  out  1  sticky: a row was dropped on full FIFO

## Operation
- Derived: NO_LOAD_FILTER = ceil(NO_FILTER/SYSTOLIC_SIZE); NO_ROW_GROUP = ceil(NO_PIXEL/SYSTOLIC_SIZE)·SYSTOLIC_SIZE rows per group.
- States IDLE, RUN, DRAIN, DONE.
- IDLE: start → RUN; row_cnt, group_cnt, overflow cleared. write_out_en ignored.
- RUN: each cycle with write_out_en is one row, pixel = row_cnt. row_cnt increments every row; at NO_ROW_GROUP−1 it wraps to 0 and group_cnt increments. Rows with pixel ≥ NO_PIXEL (padding of last tile) are counted but not pushed. After last row of group NO_LOAD_FILTER−1 → DRAIN. start ignored.
- DRAIN: no rows accepted; when pipeline stage and FIFO empty → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Per lane: x = psum; if RELU and x<0, x=0; saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- FIFO full and no pop in push cycle: row dropped, overflow=1 until next start or reset; counters still advance. Full with simultaneous pop: push accepted.
- Reset (any time): all state, counters, FIFO cleared; in-flight rows lost.

## Timing
- All outputs reset to 0.
- write_out_en sampled at edge T → post-processed row in stage register after T → FIFO push at T+1 → mem_wr_valid high from T+1 (latency 2 cycles when FIFO empty).
- mem_wr_valid/addr/data/mask driven from FIFO head; stable while valid & !ready; pop on valid&ready.
- Sustained throughput one row/cycle with mem_wr_ready high; 16 back-to-back rows never overflow.
- done asserts one cycle after last pop retires the FIFO empty.

## Structure
- Package ofm_writer_pkg: state encoding, NO_LOAD_FILTER / NO_ROW_GROUP derivation, saturate/ReLU function, mask function.
- Sub-module sync_fifo (width ADDR_W + SYSTOLIC_SIZE·(DATA_W+1), depth FIFO_DEPTH, show-ahead, full/empty, count).

## Test plan
Params for bench: SYSTOLIC_SIZE=4, NO_FILTER=6, NO_PIXEL=10, FIFO_DEPTH=8, PSUM_W=32, DATA_W=16.
- start, 24 rows, ready=1 → 20 writes, addr 0..9 then 10..19, rows 10,11 and 22,23 dropped silently, mask 4'b1111 then 4'b0011, done pulse once, overflow=0.
- Lane psum −5, 70000, −70000, 123 with RELU=1 → data 0, 32767, 0, 123; RELU=0 → −5, 32767, −32768, 123.
- ready=0 for 12 rows → 8 buffered, overflow=1, rows 9–12 lost; ready released → exactly 8 writes, addrs 0..7.
- ready toggled every cycle → valid/addr/data hold while stalled, no duplicates, no loss.
- rst_n low mid-RUN after 5 rows → all outputs 0 next cycle; new start restarts at addr 0.
- write_out_en pulses while IDLE or DRAIN → no writes, counters unchanged.
